seq_detect_param: RTL and testbench

Parametrised serial pattern detector. It recognises a compile-time bit pattern of configurable length in a 1-bit input stream, with selectable overlapping or non-overlapping detection. The match pulse is registered (Mealy decision, registered output), and matches are accumulated in a saturating counter. It is the general-purpose successor to the fixed 4-bit Mealy detectors in the serial-protocol blocks, and is instantiated wherever a framing or sync word must be spotted on a serial line.

---
 rtl/seq_detect_param.sv | 76 +++++++
 tb/tb_seq_detect_param.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector that matches with prefix-depth tracking.
// It has a registered match pulse and a saturating match counter.
module seq_detect_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             x,
    input  logic             clr_cnt,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             seen
);
    localparam int DW = $clog2(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
        $error("seq_detect_param: PAT_LEN must be within 2..16");
    end

    // Longest proper prefix of PATTERN that is a suffix of (d prefix bits, b).
    // A full match falls out as the KMP border unless non-overlapping.
    function automatic int next_depth(input int d, input bit b);
        logic [16:0] s;
        int          best;
        bit          ok;
        s    = '0;
        s[0] = b;
        for (int i = 1; i <= d; i++) s[i] = PATTERN[PAT_LEN-d-1+i];
        best = 0;
        for (int k = 1; k < PAT_LEN; k++) begin
            if (k <= d + 1) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) if (s[i] != PATTERN[PAT_LEN-k+i]) ok = 1'b0;
                if (ok) best = k;
            end
        end
        if (!OVERLAP && d == PAT_LEN - 1 && b == PATTERN[0]) best = 0;
        return best;
    endfunction

    logic [DW-1:0]    nxt [PAT_LEN][2];
    logic [DW-1:0]    d, d_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hit, seen_nxt;

    for (genvar i = 0; i < PAT_LEN; i++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_col
            assign nxt[i][b] = DW'(next_depth(i, b));
        end
    end

    always_comb begin
        hit      = en && d == DW'(PAT_LEN - 1) && x == PATTERN[0];
        d_nxt    = en ? nxt[d][x] : d;
        cnt_nxt  = clr_cnt ? CNT_W'(hit) : (hit && match_cnt != '1) ? match_cnt + 1'b1 : match_cnt;
        seen_nxt = !clr_cnt && (seen || hit);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d         <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
            seen      <= 1'b0;
        end else begin
            d         <= d_nxt;
            z         <= hit;
            match_cnt <= cnt_nxt;
            seen      <= seen_nxt;
        end
    end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: four detector configurations share one stimulus stream.
// Each cycle's expected outputs are queued and checked by an independent monitor.
module tb_seq_detect_param;
    logic clk = 1'b0, reset_n = 1'b0, en = 1'b0, x = 1'b0, clr_cnt = 1'b0;
    logic [3:0]      zv, sv;
    logic [7:0]      cnt_a, cnt_b;
    logic [1:0]      cnt_c;
    logic [3:0]      cnt_d;
    logic [3:0][7:0] cv;

    always #5 clk = ~clk;

    seq_detect_param u_a (.clk(clk), .reset_n(reset_n), .en(en), .x(x), .clr_cnt(clr_cnt),
                          .z(zv[0]), .match_cnt(cnt_a), .seen(sv[0]));
    seq_detect_param #(.OVERLAP(1'b0)) u_b (.clk(clk), .reset_n(reset_n), .en(en), .x(x),
                          .clr_cnt(clr_cnt), .z(zv[1]), .match_cnt(cnt_b), .seen(sv[1]));
    seq_detect_param #(.PAT_LEN(2), .PATTERN(2'b11), .CNT_W(2)) u_c (.clk(clk), .reset_n(reset_n),
                          .en(en), .x(x), .clr_cnt(clr_cnt), .z(zv[2]), .match_cnt(cnt_c), .seen(sv[2]));
    seq_detect_param #(.PAT_LEN(6), .PATTERN(6'b110110), .CNT_W(4)) u_d (.clk(clk), .reset_n(reset_n),
                          .en(en), .x(x), .clr_cnt(clr_cnt), .z(zv[3]), .match_cnt(cnt_d), .seen(sv[3]));

    assign cv[0] = cnt_a;
    assign cv[1] = cnt_b;
    assign cv[2] = 8'(cnt_c);
    assign cv[3] = 8'(cnt_d);

    typedef struct packed {
        logic [3:0]      z;
        logic [3:0][7:0] cnt;
        logic [3:0]      seen;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0;

    // Reference: keep the accepted bit history and compare its tail with the pattern.
    int          ml[4] = '{4, 4, 2, 6};
    int          mp[4] = '{13, 13, 3, 54};
    int          mo[4] = '{1, 0, 1, 1};
    int          mw[4] = '{8, 8, 2, 4};
    logic [31:0] hist[4];
    int          len[4], mcnt[4];
    bit          mseen[4];

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d @%0t", nm, act, want, $time);
        end
    endtask

    task automatic cyc(input bit rn, input bit e, input bit xv, input bit cl);
        exp_t ex;
        bit   m;
        @(negedge clk);
        reset_n = rn; en = e; x = xv; clr_cnt = cl;
        for (int c = 0; c < 4; c++) begin
            m = 1'b0;
            if (!rn) begin
                hist[c] = 0; len[c] = 0; mcnt[c] = 0; mseen[c] = 1'b0;
            end else begin
                if (e) begin
                    hist[c] = {hist[c][30:0], xv};
                    len[c]++;
                    m = len[c] >= ml[c] && int'(hist[c] & ((32'd1 << ml[c]) - 1)) == mp[c];
                    if (m && mo[c] == 0) len[c] = 0;
                end
                if (cl) begin
                    mcnt[c] = m ? 1 : 0;
                    mseen[c] = 1'b0;
                end else begin
                    if (m && mcnt[c] < (1 << mw[c]) - 1) mcnt[c]++;
                    mseen[c] = mseen[c] | m;
                end
            end
            ex.z[c]    = m;
            ex.cnt[c]  = 8'(mcnt[c]);
            ex.seen[c] = mseen[c];
        end
        q.push_back(ex);
    endtask

    task automatic bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, 1'b1, v[i], 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                for (int c = 0; c < 4; c++) begin
                    chk($sformatf("z%0d", c), int'(zv[c]), int'(e.z[c]));
                    chk($sformatf("cnt%0d", c), int'(cv[c]), int'(e.cnt[c]));
                    chk($sformatf("seen%0d", c), int'(sv[c]), int'(e.seen[c]));
                end
            end
        end
    end

    initial begin : driver
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 1);
        settle();
        chk("rst_cnt", int'(cnt_a), 0);
        chk("rst_z", int'(zv[0]), 0);
        bits(16'b1101101, 7);
        settle();
        chk("ov_cnt", int'(cnt_a), 2);
        chk("ov_seen", int'(sv[0]), 1);
        chk("nov_cnt", int'(cnt_b), 1);
        cyc(0, 0, 0, 0);
        bits(16'b11101, 5);
        settle();
        chk("fail_z", int'(zv[0]), 1);
        chk("fail_cnt", int'(cnt_a), 1);
        cyc(0, 0, 0, 0);
        bits(16'b110, 3);
        cyc(0, 1, 1, 0);
        cyc(1, 1, 1, 0);
        settle();
        chk("midrst_cnt", int'(cnt_a), 0);
        bits(16'b1101, 4);
        settle();
        chk("postrst_cnt", int'(cnt_a), 1);
        cyc(0, 0, 0, 0);
        bits(16'b11, 2);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        bits(16'b0, 1);
        settle();
        chk("gap_early_z", int'(zv[0]), 0);
        bits(16'b1, 1);
        settle();
        chk("gap_z", int'(zv[0]), 1);
        cyc(0, 0, 0, 0);
        bits(16'b111111, 6);
        settle();
        chk("sat_cnt", int'(cnt_c), 3);
        cyc(1, 1, 1, 1);
        settle();
        chk("clr_hit_cnt", int'(cnt_c), 1);
        chk("clr_hit_seen", int'(sv[2]), 0);
        chk("clr_hit_z", int'(zv[2]), 1);
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                $urandom_range(0, 29) == 0);
        settle();
        #2;
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
